// File: rtl/baud_gen_frac.sv
// Fractional-N baud generator: oversample and bit ticks from a modulo accumulator,
// with a valid/ready rate change applied on bit boundaries. Optional: BAUD_GEN_FRAC_BITCNT_EN.
module baud_gen_frac #(
  parameter int unsigned CLK_FREQ_HZ = 1_600_000,
  parameter int unsigned OVERSAMPLE  = 8,
  parameter int unsigned INC_W       = 24,
  parameter int unsigned DEFAULT_INC = 800_000,
  localparam int unsigned PH_W       = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             align,
  input  logic [INC_W-1:0] cfg_inc,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             os_tick,
  output logic             bit_tick,
  output logic [PH_W-1:0]  os_phase
`ifdef BAUD_GEN_FRAC_BITCNT_EN
  ,
  output logic [15:0]      bit_count
`endif
);

  typedef enum logic {CFG_IDLE, CFG_PENDING} cfg_state_t;

  localparam logic [32:0]     MOD     = 33'(CLK_FREQ_HZ);
  localparam logic [31:0]     HALF    = 32'(CLK_FREQ_HZ / 2);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
  localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVERSAMPLE / 2);

  logic [31:0]      acc_reg, acc_next;
  logic [PH_W-1:0]  os_phase_reg, os_phase_next;
  logic [INC_W-1:0] inc_active_reg, inc_active_next;
  logic [INC_W-1:0] pending_reg, pending_next;
  cfg_state_t       state_reg, state_next;
  logic             os_tick_reg, os_tick_next;
  logic             bit_tick_reg, bit_tick_next;
  logic             cfg_err_reg, cfg_err_next;

  logic [32:0] sum;
  logic        wrap;
  logic        cfg_bad;
  logic        apply;

  // Sum is one bit wider than acc so the modulus compare never overflows
  always_comb begin
    sum     = {1'b0, acc_reg} + 33'(inc_active_reg);
    wrap    = (sum >= MOD);
    cfg_bad = (cfg_inc == '0) || (33'(cfg_inc) >= MOD);
  end

  always_comb begin
    acc_next      = acc_reg;
    os_phase_next = os_phase_reg;
    os_tick_next  = 1'b0;
    bit_tick_next = 1'b0;
    if (!en) begin
      acc_next      = '0;
      os_phase_next = '0;
    end else if (align) begin
      acc_next      = HALF;
      os_phase_next = PH_MID;
    end else if (wrap) begin
      acc_next     = 32'(sum - MOD);
      os_tick_next = 1'b1;
      if (os_phase_reg == PH_LAST) begin
        os_phase_next = '0;
        bit_tick_next = 1'b1;
      end else begin
        os_phase_next = os_phase_reg + 1'b1;
      end
    end else begin
      acc_next = sum[31:0];
    end
  end

  // The bit_tick cycle itself still runs on the old increment
  always_comb begin
    state_next      = state_reg;
    pending_next    = pending_reg;
    inc_active_next = inc_active_reg;
    cfg_err_next    = 1'b0;
    apply           = !en || align || bit_tick_next;
    case (state_reg)
      CFG_IDLE: begin
        if (cfg_valid) begin
          if (cfg_bad) begin
            cfg_err_next = 1'b1;
          end else begin
            pending_next = cfg_inc;
            state_next   = CFG_PENDING;
          end
        end
      end
      CFG_PENDING: begin
        if (apply) begin
          inc_active_next = pending_reg;
          state_next      = CFG_IDLE;
        end
      end
      default: state_next = CFG_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg        <= '0;
      os_phase_reg   <= '0;
      inc_active_reg <= INC_W'(DEFAULT_INC);
      pending_reg    <= '0;
      state_reg      <= CFG_IDLE;
      os_tick_reg    <= 1'b0;
      bit_tick_reg   <= 1'b0;
      cfg_err_reg    <= 1'b0;
    end else begin
      acc_reg        <= acc_next;
      os_phase_reg   <= os_phase_next;
      inc_active_reg <= inc_active_next;
      pending_reg    <= pending_next;
      state_reg      <= state_next;
      os_tick_reg    <= os_tick_next;
      bit_tick_reg   <= bit_tick_next;
      cfg_err_reg    <= cfg_err_next;
    end
  end

  assign cfg_ready = (state_reg == CFG_IDLE);
  assign cfg_err   = cfg_err_reg;
  assign os_tick   = os_tick_reg;
  assign bit_tick  = bit_tick_reg;
  assign os_phase  = os_phase_reg;

`ifdef BAUD_GEN_FRAC_BITCNT_EN
  logic [15:0] bit_count_reg, bit_count_next;

  always_comb begin
    bit_count_next = bit_count_reg;
    if (!en || align) begin
      bit_count_next = '0;
    end else if (bit_tick_next && (bit_count_reg != 16'hFFFF)) begin
      bit_count_next = bit_count_reg + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_count_reg <= '0;
    end else begin
      bit_count_reg <= bit_count_next;
    end
  end

  assign bit_count = bit_count_reg;
`else
  // Bit counter not built in this configuration
`endif

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac: tick rates, config handshake, align, enable and reset.
module tb_baud_gen_frac;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        align;
  logic [23:0] cfg_inc;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        cfg_err;
  logic        os_tick;
  logic        bit_tick;
  logic [2:0]  os_phase;
`ifdef BAUD_GEN_FRAC_BITCNT_EN
  logic [15:0] bit_count;
`endif

  baud_gen_frac dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .align     (align),
    .cfg_inc   (cfg_inc),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .os_tick   (os_tick),
    .bit_tick  (bit_tick),
    .os_phase  (os_phase)
`ifdef BAUD_GEN_FRAC_BITCNT_EN
    ,
    .bit_count (bit_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int last_os    = 0;
  int os_cnt     = 0;
  int bit_cnt    = 0;
  int min_gap    = 1_000_000;
  int max_gap    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) begin
      $display("vec %0d %s obs=%0d exp=%0d ok", vectors, tag, obs, exp);
    end else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    os_cnt  = 0;
    bit_cnt = 0;
    min_gap = 1_000_000;
    max_gap = 0;
  endtask

  // Advance n clocks, sampling outputs on each falling edge
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (os_tick === 1'b1) begin
        int gap;
        gap = cyc - last_os;
        if (gap < min_gap) min_gap = gap;
        if (gap > max_gap) max_gap = gap;
        last_os = cyc;
        os_cnt++;
      end
      if (bit_tick === 1'b1) bit_cnt++;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    align     = 1'b0;
    cfg_inc   = '0;
    cfg_valid = 1'b0;

    // Reset values
    step(2);
    check("rst_ready", 32'(cfg_ready), 1);
    check("rst_os", 32'(os_tick), 0);
    check("rst_bit", 32'(bit_tick), 0);
    check("rst_err", 32'(cfg_err), 0);
    check("rst_phase", 32'(os_phase), 0);

    // 1: default rate for 160 cycles; 300k request lands on the last bit boundary
    rst_n = 1'b1;
    en    = 1'b1;
    clear_stats();
    last_os = cyc;
    step(158);
    cfg_inc   = 24'd300_000;
    cfg_valid = 1'b1;
    step(1);
    check("t1_pending_ready", 32'(cfg_ready), 0);
    cfg_valid = 1'b0;
    step(1);
    check("t1_boundary_bit", 32'(bit_tick), 1);
    check("t1_ready_back", 32'(cfg_ready), 1);
    check("t1_os_count", 32'(os_cnt), 80);
    check("t1_bit_count", 32'(bit_cnt), 10);
    check("t1_min_gap", 32'(min_gap), 2);
    check("t1_max_gap", 32'(max_gap), 2);

    // 2: 300k for 1600 cycles
    clear_stats();
    step(1600);
    check("t2_os_count", 32'(os_cnt), 300);
    check("t2_bit_count", 32'(bit_cnt), 37);
    check("t2_min_gap", 32'(min_gap), 5);
    check("t2_max_gap", 32'(max_gap), 6);
    check("t2_phase", 32'(os_phase), 4);

    // Restore default rate through an enable-low window
    en        = 1'b0;
    cfg_inc   = 24'd800_000;
    cfg_valid = 1'b1;
    step(1);
    check("rs_ready_low", 32'(cfg_ready), 0);
    check("rs_phase", 32'(os_phase), 0);
    check("rs_os", 32'(os_tick), 0);
    cfg_valid = 1'b0;
    step(1);
    check("rs_ready_back", 32'(cfg_ready), 1);
    en = 1'b1;

    // 3: mid-bit request for 400k
    clear_stats();
    last_os = cyc;
    step(6);
    cfg_inc   = 24'd400_000;
    cfg_valid = 1'b1;
    step(1);
    check("t3_ready_low", 32'(cfg_ready), 0);
    cfg_valid = 1'b0;
    step(8);
    check("t3_ready_still_low", 32'(cfg_ready), 0);
    step(1);
    check("t3_bit", 32'(bit_tick), 1);
    check("t3_ready_back", 32'(cfg_ready), 1);
    check("t3_old_min_gap", 32'(min_gap), 2);
    check("t3_old_max_gap", 32'(max_gap), 2);
    clear_stats();
    step(16);
    check("t3_new_os_count", 32'(os_cnt), 4);
    check("t3_new_min_gap", 32'(min_gap), 4);
    check("t3_new_max_gap", 32'(max_gap), 4);

    // 4: rejected configs
    cfg_inc   = 24'd0;
    cfg_valid = 1'b1;
    step(1);
    check("t4_err_zero", 32'(cfg_err), 1);
    check("t4_ready_zero", 32'(cfg_ready), 1);
    cfg_valid = 1'b0;
    step(1);
    check("t4_err_clear1", 32'(cfg_err), 0);
    cfg_inc   = 24'd1_600_000;
    cfg_valid = 1'b1;
    step(1);
    check("t4_err_max", 32'(cfg_err), 1);
    check("t4_ready_max", 32'(cfg_ready), 1);
    cfg_valid = 1'b0;
    step(1);
    check("t4_err_clear2", 32'(cfg_err), 0);
    clear_stats();
    step(16);
    check("t4_os_count", 32'(os_cnt), 4);
    check("t4_min_gap", 32'(min_gap), 4);
    check("t4_max_gap", 32'(max_gap), 4);

    // 5: align; it also applies a pending default-rate request
    cfg_inc   = 24'd800_000;
    cfg_valid = 1'b1;
    step(1);
    check("t5_ready_low", 32'(cfg_ready), 0);
    cfg_valid = 1'b0;
    align     = 1'b1;
    step(1);
    align = 1'b0;
    check("t5_align_os", 32'(os_tick), 0);
    check("t5_align_phase", 32'(os_phase), 4);
    check("t5_align_ready", 32'(cfg_ready), 1);
    step(1);
    check("t5_os_p5", 32'(os_tick), 1);
    check("t5_phase5", 32'(os_phase), 5);
    step(2);
    check("t5_os_p6", 32'(os_tick), 1);
    check("t5_phase6", 32'(os_phase), 6);
    step(2);
    check("t5_os_p7", 32'(os_tick), 1);
    check("t5_phase7", 32'(os_phase), 7);
    check("t5_nobit_p7", 32'(bit_tick), 0);
    step(2);
    check("t5_os_p0", 32'(os_tick), 1);
    check("t5_bit_at7", 32'(bit_tick), 1);
    check("t5_phase0", 32'(os_phase), 0);
`ifdef BAUD_GEN_FRAC_BITCNT_EN
    check("t5_bitcount1", 32'(bit_count), 1);
`endif
    // align on a cycle that would otherwise wrap
    step(1);
    align = 1'b1;
    step(1);
    align = 1'b0;
    check("t5_align_wins_os", 32'(os_tick), 0);
    check("t5_align_wins_phase", 32'(os_phase), 4);
`ifdef BAUD_GEN_FRAC_BITCNT_EN
    check("t5_bitcount_align", 32'(bit_count), 0);
`endif

    // 6a: one-cycle enable drop mid-bit
    step(3);
    check("t6_pre_phase", 32'(os_phase), 6);
    en = 1'b0;
    step(1);
    en = 1'b1;
    check("t6_en_os", 32'(os_tick), 0);
    check("t6_en_phase", 32'(os_phase), 0);
    clear_stats();
    step(15);
    check("t6_no_early_bit", 32'(bit_cnt), 0);
    step(1);
    check("t6_bit_16", 32'(bit_tick), 1);
`ifdef BAUD_GEN_FRAC_BITCNT_EN
    check("t6_bitcount1", 32'(bit_count), 1);
`endif

    // 6b: reset while a 400k request is pending
    cfg_inc   = 24'd400_000;
    cfg_valid = 1'b1;
    step(1);
    check("t6_pending", 32'(cfg_ready), 0);
    cfg_valid = 1'b0;
    step(3);
    check("t6_pre_rst_os", 32'(os_tick), 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_ready", 32'(cfg_ready), 1);
    check("t6_rst_os", 32'(os_tick), 0);
    check("t6_rst_bit", 32'(bit_tick), 0);
    check("t6_rst_err", 32'(cfg_err), 0);
    check("t6_rst_phase", 32'(os_phase), 0);
`ifdef BAUD_GEN_FRAC_BITCNT_EN
    check("t6_rst_bitcount", 32'(bit_count), 0);
`endif
    step(1);
    rst_n = 1'b1;
    clear_stats();
    last_os = cyc;
    step(16);
    check("t6_default_os", 32'(os_cnt), 8);
    check("t6_default_bit", 32'(bit_cnt), 1);
    check("t6_default_min_gap", 32'(min_gap), 2);
    check("t6_default_max_gap", 32'(max_gap), 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/baud_gen_frac.md
Name: baud_gen_frac

Overview:
- Next-generation fractional-N baud generator for the UART datapath.
- Generates an oversampled tick (`os_tick`) for RX sampling and a bit-rate tick (`bit_tick`) for TX shifting.
- The rate is runtime-programmable through a valid/ready config handshake. A new rate takes effect only on a bit boundary, so no bit is ever stretched or cut short.
- Sits between the register interface and the uart_tx/uart_rx cores.

Parameters:
- CLK_FREQ_HZ, 1_600_000, system clock frequency; also the accumulator modulus.
- OVERSAMPLE, 8, os_ticks per bit; integer ≥ 2, even.
- INC_W, 24, width of `cfg_inc`.
- DEFAULT_INC, 800_000, increment loaded at reset (100 kbaud × 8).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `en`  in  1  generator enable; low clears phase.
- `align`  in  1  one-cycle pulse; re-phase to mid-bit (RX start-edge detect).
- `cfg_inc`  in  INC_W  requested increment = baud × OVERSAMPLE, in Hz.
- `cfg_valid`  in  1  config request valid.
- `cfg_ready`  out  1  ready to accept config.
- `cfg_err`  out  1  one-cycle pulse: rejected config.
- `os_tick`  out  1  oversample tick, one cycle wide.
- `bit_tick`  out  1  bit tick, one cycle wide, coincident with an os_tick.
- `os_phase`  out  $clog2(OVERSAMPLE)  current oversample index.

Behaviour:
- Reset (async, rst_n low):
  - acc=0, os_phase=0, inc_active=DEFAULT_INC, cfg state IDLE, pending discarded.
  - cfg_ready=1, os_tick=0, bit_tick=0, cfg_err=0.
- Accumulator `acc` is 32 bit and always holds a value in [0, CLK_FREQ_HZ). The sum is formed at 33 bits.
- Priority per cycle: !en > align > accumulate.
- `en` low:
  - acc←0, os_phase←0.
  - os_tick and bit_tick forced 0.
  - A pending config is applied immediately.
- `align` high (with en high):
  - acc←CLK_FREQ_HZ/2, os_phase←OVERSAMPLE/2, no tick that cycle.
  - A pending config is applied immediately.
- Accumulate:
  - next = acc + inc_active.
  - If next ≥ CLK_FREQ_HZ: acc←next−CLK_FREQ_HZ, os_tick←1, os_phase←os_phase+1 mod OVERSAMPLE. If os_phase was OVERSAMPLE−1, bit_tick←1 as well.
  - Else: acc←next.
- All ticks are registered, visible the cycle after the deciding edge. Long-term frequency error is 0.
- Config FSM:
  - IDLE: cfg_ready=1. On cfg_valid&&cfg_ready:
    - If cfg_inc==0 or cfg_inc ≥ CLK_FREQ_HZ: cfg_err←1 for one cycle, stay IDLE, inc_active unchanged.
    - Else: pending←cfg_inc, go to PENDING.
  - PENDING: cfg_ready=0. Exit to IDLE and set inc_active←pending on the first edge that does one of:
    - sets bit_tick;
    - sees en low;
    - sees align.
- Apply rule: the cycle that generates bit_tick still uses the old increment; the new increment is used from the next accumulate.
- Simultaneous events:
  - align and a wrap in the same cycle: align wins, no tick.
  - cfg_valid in PENDING is ignored (not acknowledged).
- `os_phase` is a registered copy of the counter.

Optional Feature:
- Macro: BAUD_GEN_FRAC_BITCNT_EN.
- Defined:
  - Adds output port `bit_count` [15:0].
  - Increments on each bit_tick and saturates at 16'hFFFF.
  - Cleared by reset, en low and align.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
1. Reset, en=1, default config, 160 cycles:
   - os_tick every 2nd cycle: exactly 80 os_ticks.
   - bit_tick every 16 cycles: exactly 10 bit_ticks.
2. Config cfg_inc=300_000, accepted at a bit boundary, run 1600 cycles:
   - Exactly 300 os_ticks, os_tick spacing 5 or 6 cycles only.
   - Exactly 37 bit_ticks (37.5 bits elapsed); no drift.
3. cfg_valid mid-bit with cfg_inc=400_000:
   - cfg_ready drops for the remainder of the bit.
   - Old spacing (2 cycles) is kept through that bit_tick; spacing is 4 cycles afterwards.
   - cfg_ready returns to 1.
4. cfg_inc=0, then cfg_inc=1_600_000:
   - Each gives a one-cycle cfg_err pulse.
   - cfg_ready stays 1 and tick spacing is unchanged.
5. align pulse with default rate:
   - No tick in the align cycle.
   - os_ticks occur at os_phase 5, 6, 7, 0.
   - bit_tick is visible 7 clocks after the align edge.
6. Interruptions:
   - en low for 1 cycle mid-bit: next bit_tick comes 16 cycles after en returns.
   - rst_n asserted while in PENDING: pending is discarded, rate back to DEFAULT_INC, all outputs 0.
   - With BAUD_GEN_FRAC_BITCNT_EN defined, additionally check that bit_count clears.
